sha256_msg_sched: RTL and testbench
===================================

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 No parameters; word width fixed at 32 bits, schedule length fixed at 64 words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort; returns block to IDLE.
REQ-005 blk_valid  input  1  512-bit message block offered.
REQ-006 blk_ready  output  1  block can accept a message block.
REQ-007 blk_data  input  512  message block; word M0 in bits [511:480], M15 in bits [31:0].
REQ-008 w_valid  output  1  w_data holds a valid schedule word.
REQ-009 w_ready  input  1  downstream round stage accepts w_data.
REQ-010 w_data  output  32  schedule word W[t].
REQ-011 w_idx  output  6  index t of w_data, 0..63.
REQ-012 w_last  output  1  high with w_valid when w_idx == 63.

Function
REQ-013 Block SHALL implement a two-state FSM: IDLE and EMIT.
REQ-014 IDLE: blk_ready = 1, w_valid = 0; blk_valid & blk_ready -> load 16-word window from blk_data, t = 0, go EMIT.
REQ-015 EMIT: blk_ready = 0; w_valid = 1 every cycle in EMIT.
REQ-016 Latency: W0 SHALL be on w_data with w_valid high in the cycle after the block handshake.
REQ-017 Output transfer occurs only when w_valid & w_ready; no transfer -> w_data, w_idx, w_last held stable.
REQ-018 For t = 0..15, w_data = M[t] unmodified.
REQ-019 For t = 16..63, w_data = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32, carries beyond bit 31 discarded.
REQ-020 sigma0(x) = ROTR7(x) XOR ROTR18(x) XOR SHR3(x); sigma1(x) = ROTR17(x) XOR ROTR19(x) XOR SHR10(x); rotates are circular 32-bit right rotates.
REQ-021 Storage: 16-word sliding window, shifted one word per accepted transfer; newly computed word enters the window end; no 64-word array.
REQ-022 The next word SHALL be computed and registered in the same cycle as the transfer, so back-to-back transfers with w_ready held high yield 64 words in 64 consecutive cycles.
REQ-023 w_idx increments by 1 per transfer; w_last = 1 iff w_idx == 63.
REQ-024 Transfer of W63 -> FSM to IDLE next cycle; w_valid = 0, blk_ready = 1 that cycle.
REQ-025 No new block is accepted while in EMIT; blk_valid in EMIT is ignored and SHALL NOT disturb the window.
REQ-026 clear = 1 (any state) -> next cycle IDLE, w_valid = 0, w_idx = 0; clear has priority over a simultaneous block handshake or output transfer.
REQ-027 w_ready toggling arbitrarily SHALL NOT skip, duplicate or reorder words.

Reset
REQ-028 rst_n low SHALL immediately force IDLE: w_valid = 0, w_last = 0, w_idx = 0, w_data = 0, blk_ready = 1 after release, window contents zero.
REQ-029 Reset asserted mid-EMIT SHALL abandon the block; after release the first W0 seen is from the next accepted block.
REQ-030 Reset deassertion is synchronised internally; first block handshake is possible on the first rising edge after release.

Verification
REQ-031 Block "abc" padded (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1 -> W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, 64 words in 64 cycles, w_last only on W63.
REQ-032 Same block, w_ready random 50% -> identical 64-word sequence vs. reference model; w_data stable during every stall cycle.
REQ-033 blk_valid held high throughout EMIT with different data -> schedule unaffected; second block accepted in cycle after W63 transfer.
REQ-034 rst_n pulsed low at t = 30 -> outputs zero immediately; fresh block after release produces W0 = its M0 at w_idx = 0.
REQ-035 clear asserted in same cycle as W20 transfer -> IDLE next cycle, w_valid = 0, blk_ready = 1.
REQ-036 Random 512-bit blocks (>=1000) vs. software SHA-256 schedule model -> all 64 words match, including sums overflowing 2^32.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63]
// from a 16-word sliding window, one word per accepted transfer.
module sha256_msg_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_data,
   output logic [5:0]   w_idx,
   output logic         w_last
);

   typedef enum logic {
      S_IDLE,
      S_EMIT
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_win [16];
   logic [5:0]  r_idx;
   logic        w_load;
   logic        w_xfer;
   logic [31:0] w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Window holds W[t..t+15]; this is W[t+16], ready for the shift.
   assign w_new = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

   assign w_data = r_win[0];
   assign w_idx  = r_idx;
   assign w_last = (r_idx == 6'd63);

   always_comb begin
      w_state_nxt = r_state;
      blk_ready   = 1'b0;
      w_valid     = 1'b0;
      w_load      = 1'b0;
      w_xfer      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            w_valid = 1'b1;
            if (w_ready) begin
               w_xfer = 1'b1;
               if (r_idx == 6'd63) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_load      = 1'b0;
         w_xfer      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= 6'd0;
         for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
      end else if (clear) begin
         r_idx <= 6'd0;
      end else if (w_load) begin
         r_idx <= 6'd0;
         for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511-32*i -: 32];
      end else if (w_xfer) begin
         // 63 + 1 wraps to 0, leaving the index clean for the next block
         r_idx <= r_idx + 6'd1;
         for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
         r_win[15] <= w_new;
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed and random checks of sha256_msg_sched against an
// array-based SHA-256 schedule model.
module tb_sha256_msg_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;

   int checks = 0;
   int errors = 0;

   logic [31:0] got_d [64];
   logic [5:0]  got_i [64];
   logic        got_l [64];
   logic [31:0] exp_w [64];

   typedef struct {
      int          idx;
      logic [31:0] d;
   } vec_t;

   vec_t tbl [6];

   sha256_msg_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic model(input logic [511:0] b);
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
         s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
         exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
      return b;
   endfunction

   task automatic send(input logic [511:0] b, input bit hold);
      @(negedge clk);
      check("blk_ready_idle", 64'(blk_ready), 64'd1);
      blk_valid = 1'b1;
      blk_data  = b;
      @(posedge clk);
      #1;
      if (!hold) blk_valid = 1'b0;
   endtask

   task automatic collect(input bit rnd, input int maxw,
                          output int n, output int cyc);
      bit          stalled;
      bit          rdy, v, l;
      logic [31:0] d, hd;
      logic [5:0]  i, hi;
      n = 0;
      cyc = 0;
      stalled = 0;
      hd = '0;
      hi = '0;
      while (n < maxw && cyc < 1000) begin
         @(negedge clk);
         check("w_valid_emit", 64'(w_valid), 64'd1);
         if (stalled)
            check("stall_hold", {26'd0, w_idx, w_data}, {26'd0, hi, hd});
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         w_ready = rdy;
         d = w_data;
         i = w_idx;
         l = w_last;
         v = w_valid;
         @(posedge clk);
         cyc++;
         if (v && rdy) begin
            got_d[n] = d;
            got_i[n] = i;
            got_l[n] = l;
            n++;
            stalled = 0;
         end else begin
            stalled = v;
            hd = d;
            hi = i;
         end
      end
      #1;
      w_ready = 1'b0;
      if (n < maxw) check("collect_timeout", 64'(n), 64'(maxw));
   endtask

   task automatic verify(input string name, input int n);
      for (int k = 0; k < n; k++)
         check(name, {25'd0, got_l[k], got_i[k], got_d[k]},
               {25'd0, 1'(k == 63), 6'(k), exp_w[k]});
   endtask

   initial begin
      logic [511:0] abc, b2, b3;
      int n, cyc;

      tbl[0] = '{0, 32'h61626380};
      tbl[1] = '{1, 32'h00000000};
      tbl[2] = '{14, 32'h00000000};
      tbl[3] = '{15, 32'h00000018};
      tbl[4] = '{16, 32'h61626380};
      tbl[5] = '{17, 32'h000F0000};

      abc = '0;
      abc[511:480] = 32'h61626380;
      abc[31:0]    = 32'h00000018;

      rst_n = 1'b0;
      clear = 1'b0;
      blk_valid = 1'b0;
      blk_data = '0;
      w_ready = 1'b0;
      #12;
      check("reset_outs", {w_valid, w_last, blk_ready, w_idx, w_data},
            {1'b0, 1'b0, 1'b1, 6'd0, 32'd0});
      @(negedge clk);
      rst_n = 1'b1;

      // abc block, w_ready held high
      send(abc, 0);
      collect(0, 64, n, cyc);
      check("abc_cycles", 64'(cyc), 64'd64);
      for (int k = 0; k < 6; k++)
         check("abc_table", {26'd0, got_i[tbl[k].idx], got_d[tbl[k].idx]},
               {26'd0, 6'(tbl[k].idx), tbl[k].d});
      model(abc);
      verify("abc_word", n);
      @(negedge clk);
      check("abc_done", {62'd0, w_valid, blk_ready}, {62'd0, 1'b0, 1'b1});

      // abc block, random backpressure
      send(abc, 0);
      collect(1, 64, n, cyc);
      verify("abc_stall_word", n);

      // blk_valid held during EMIT with other data
      b2 = rand_blk();
      send(abc, 1);
      blk_data = b2;
      collect(0, 64, n, cyc);
      verify("hold_word", n);
      @(negedge clk);
      check("hold_done", {62'd0, w_valid, blk_ready}, {62'd0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      collect(0, 64, n, cyc);
      model(b2);
      verify("second_blk_word", n);

      // reset mid-block at t = 30
      send(abc, 0);
      collect(0, 30, n, cyc);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_outs", {w_valid, w_last, blk_ready, w_idx, w_data},
            {1'b0, 1'b0, 1'b1, 6'd0, 32'd0});
      b3 = rand_blk();
      blk_valid = 1'b1;
      blk_data = b3;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      collect(0, 64, n, cyc);
      model(b3);
      verify("post_reset_word", n);

      // clear during the W20 transfer
      send(abc, 0);
      collect(0, 20, n, cyc);
      @(negedge clk);
      check("pre_clear_idx", 64'(w_idx), 64'd20);
      w_ready = 1'b1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      w_ready = 1'b0;
      @(negedge clk);
      check("clear_outs", {w_valid, blk_ready, w_idx}, {1'b0, 1'b1, 6'd0});

      // clear beats a handshake in IDLE
      blk_valid = 1'b1;
      blk_data = b2;
      clear = 1'b1;
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      check("clear_vs_hs", {62'd0, w_valid, blk_ready}, {62'd0, 1'b0, 1'b1});

      // random blocks; the first few with backpressure
      for (int r = 0; r < 1000; r++) begin
         b3 = rand_blk();
         send(b3, 0);
         collect(r < 20, 64, n, cyc);
         model(b3);
         verify("rand_word", n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
